// File: rtl/score_digit_encoder_if.sv
// score_digit_encoder_if: groups the score load handshake and the held-digit read port.
// Latency: none; this is wiring only.
// Backpressure: busy from the encoder means load is dropped rather than queued.
// Ports: master = score source and display reader (drives score_in/load/digit_sel),
//        slave  = encoder (drives busy/done/overflow/digit/digit_blank).
interface score_digit_encoder_if #(
  parameter int SCORE_W = 14
);
  logic [SCORE_W-1:0] score_in;
  logic               load;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [1:0]         digit_sel;
  logic [3:0]         digit;
  logic               digit_blank;

  modport master (
    output score_in, load, digit_sel,
    input  busy, done, overflow, digit, digit_blank
  );

  modport slave (
    input  score_in, load, digit_sel,
    output busy, done, overflow, digit, digit_blank
  );
endinterface

// File: rtl/score_digit_encoder.sv
// score_digit_encoder: converts a binary score (saturated at 9999) to four held BCD digits
// for the 14x14 digit font block, using a shift-and-add-3 converter.
// Latency: load accepted in cycle N -> done pulse and new digits in cycle N+SCORE_W+1.
// Backpressure: busy=1 during conversion; a load seen while busy is dropped, never queued.
// Ports: Clk (rising edge), Reset (synchronous, active high), bus (slave modport):
//   score_in/load in, busy/done/overflow out, digit_sel in, digit/digit_blank out.
// Build option: define LEADING_ZERO_BLANK_EN to flag suppressed leading zeros on
//   digit_blank; without it digit_blank is held at 0.
module score_digit_encoder #(
  parameter int SCORE_W = 14
) (
  input  logic                  Clk,
  input  logic                  Reset,
  score_digit_encoder_if.slave  bus
);

  localparam int         EXT_W    = (SCORE_W > 14) ? SCORE_W : 14;
  localparam logic [3:0] CNT_LAST = 4'(SCORE_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] bin_q;
  logic [15:0]        bcd_q;
  logic [3:0]         cnt_q;
  logic [3:0]         held_q [4];
  logic               ovf_q;

  logic               accept;
  logic               last_shift;
  logic               busy_c;
  logic               done_c;
  logic               sat;
  logic [EXT_W-1:0]   score_ext;
  logic [15:0]        bcd_adj;
  logic [15:0]        bcd_nxt;
  logic [SCORE_W-1:0] bin_nxt;
  logic               digit_blank_c;
  logic               unused_adj_msb;

  // Scores wider than the 4-digit display clamp to 9999.
  assign score_ext = EXT_W'(bus.score_in);
  assign sat       = (score_ext > EXT_W'(9999));

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? (bcd_q[i*4 +: 4] + 4'd3)
                                                     : bcd_q[i*4 +: 4];
    end
  end

  // {bcd, bin} shifted left by one; the corrected thousands MSB is always 0
  // for results up to 9999, so it falls off the top.
  assign bcd_nxt        = {bcd_adj[14:0], bin_q[SCORE_W-1]};
  assign bin_nxt        = {bin_q[SCORE_W-2:0], 1'b0};
  assign unused_adj_msb = bcd_adj[15];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    accept     = 1'b0;
    last_shift = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last_shift = 1'b1;
          state_nxt  = COMMIT;
        end
      end
      COMMIT: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 4; i++) held_q[i] <= '0;
    end else if (accept) begin
      bin_q <= sat ? SCORE_W'(9999) : bus.score_in;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= sat;
    end else if (state == SHIFT) begin
      bin_q <= bin_nxt;
      bcd_q <= bcd_nxt;
      cnt_q <= cnt_q + 4'd1;
      // Held digits are loaded on the edge into COMMIT so they are visible in
      // the same cycle as the done pulse; they never change during SHIFT.
      if (last_shift) begin
        for (int i = 0; i < 4; i++) held_q[i] <= bcd_nxt[i*4 +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero;
  // the ones digit always shows.
  always_comb begin
    digit_blank_c = 1'b0;
    case (bus.digit_sel)
      2'd1:    digit_blank_c = (held_q[1] == 4'd0) && (held_q[2] == 4'd0) && (held_q[3] == 4'd0);
      2'd2:    digit_blank_c = (held_q[2] == 4'd0) && (held_q[3] == 4'd0);
      2'd3:    digit_blank_c = (held_q[3] == 4'd0);
      default: digit_blank_c = 1'b0;
    endcase
  end
`else
  assign digit_blank_c = 1'b0;
`endif

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.overflow    = ovf_q;
  assign bus.digit       = held_q[bus.digit_sel];
  assign bus.digit_blank = digit_blank_c;

endmodule
